// File: rtl/fetch_unit.sv
// Program counter and fetch sequencing: start/halt handshake, branch/jump
// target selection through a small software-loadable signed offset table.
module fetch_unit #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Stall,
  input  logic             Jump,
  input  logic             BranchEn,
  input  logic             Zero,
  input  logic [1:0]       TargSel,
  input  logic             Ack,
  input  logic             TargWrEn,
  input  logic [1:0]       TargWrIdx,
  input  logic [OFF_W-1:0] TargWrData,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [OFF_W-1:0] r_targ [4];
  logic [OFF_W-1:0] w_off;
  logic [PC_W+OFF_W-1:0] w_off_wide;
  logic [PC_W-1:0]  w_off_ext;
  logic             w_taken;

  // Replicate the sign bit far enough that any PC_W/OFF_W combination works,
  // then keep the low PC_W bits (modulo-2^PC_W add).
  assign w_off      = r_targ[TargSel];
  assign w_off_wide = {{PC_W{w_off[OFF_W-1]}}, w_off};
  assign w_off_ext  = w_off_wide[PC_W-1:0];
  assign w_taken    = Jump | (BranchEn & Zero);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Table read above sees the pre-write value, so a same-cycle write/read
  // returns the old offset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < 4; i++) r_targ[i] <= '0;
    end else if (TargWrEn) begin
      r_targ[TargWrIdx] <= TargWrData;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    unique case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = StartAddr;
        end
      end
      S_RUN: begin
        if (Start) begin
          w_pc_nxt = StartAddr;
        end else if (Stall) begin
          w_pc_nxt = r_pc;
        end else if (Ack) begin
          w_state_nxt = S_HALT;
        end else if (w_taken) begin
          w_pc_nxt = r_pc + w_off_ext;
        end else begin
          w_pc_nxt = r_pc + PC_W'(1);
        end
      end
      S_HALT: begin
        if (Start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = StartAddr;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = '0;
      end
    endcase
  end

  assign ProgCtr = r_pc;
  assign Running = (r_state == S_RUN);
  assign Done    = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a reference model pushes expected
// {ProgCtr, Running, Done} per cycle; a monitor pops and compares after each edge.
module tb_fetch_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [9:0] StartAddr;
  logic       Stall;
  logic       Jump;
  logic       BranchEn;
  logic       Zero;
  logic [1:0] TargSel;
  logic       Ack;
  logic       TargWrEn;
  logic [1:0] TargWrIdx;
  logic [7:0] TargWrData;
  logic [9:0] ProgCtr;
  logic       Running;
  logic       Done;

  int checks = 0;
  int errors = 0;

  logic [11:0] sb[$];

  logic [9:0] m_pc;
  int         m_st;
  logic [7:0] m_tab [4];

  fetch_unit #(.PC_W(10), .OFF_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .Jump(Jump), .BranchEn(BranchEn), .Zero(Zero),
    .TargSel(TargSel), .Ack(Ack), .TargWrEn(TargWrEn), .TargWrIdx(TargWrIdx),
    .TargWrData(TargWrData), .ProgCtr(ProgCtr), .Running(Running), .Done(Done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    logic [11:0] e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({ProgCtr, Running, Done} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got pc=%h run=%b done=%b exp pc=%h run=%b done=%b",
                 $time, ProgCtr, Running, Done, e[11:2], e[1], e[0]);
      end
    end
  end

  task automatic model_reset();
    m_pc = '0;
    m_st = 0;
    for (int i = 0; i < 4; i++) m_tab[i] = '0;
  endtask

  task automatic clr();
    Start = 0; StartAddr = '0; Stall = 0; Jump = 0; BranchEn = 0; Zero = 0;
    TargSel = '0; Ack = 0; TargWrEn = 0; TargWrIdx = '0; TargWrData = '0;
  endtask

  // Predict the next cycle from the current inputs, push it, then advance one edge.
  task automatic tick();
    logic [9:0] npc;
    int         nst;
    logic [7:0] off;
    npc = m_pc;
    nst = m_st;
    off = m_tab[TargSel];
    if (m_st == 0 || m_st == 2) begin
      if (Start) begin nst = 1; npc = StartAddr; end
    end else begin
      if (Start) npc = StartAddr;
      else if (Stall) npc = m_pc;
      else if (Ack) nst = 2;
      else if (Jump || (BranchEn && Zero)) npc = m_pc + {{2{off[7]}}, off};
      else npc = m_pc + 10'd1;
    end
    sb.push_back({npc, nst == 1, nst == 2});
    if (TargWrEn) m_tab[TargWrIdx] = TargWrData;
    m_pc = npc;
    m_st = nst;
    @(posedge Clk);
    #2;
  endtask

  task automatic expect_pc(input string name, input logic [9:0] exp);
    checks++;
    if (ProgCtr !== exp) begin
      errors++;
      $display("FAIL %s ProgCtr got %h exp %h", name, ProgCtr, exp);
    end
  endtask

  task automatic start_at(input logic [9:0] a);
    clr(); Start = 1; StartAddr = a; tick(); clr();
  endtask

  task automatic test_reset();
    clr();
    Reset = 0;
    #17;
    checks++;
    if ({ProgCtr, Running, Done} !== 12'h000) begin
      errors++;
      $display("FAIL reset got pc=%h run=%b done=%b exp 000/0/0", ProgCtr, Running, Done);
    end
    model_reset();
    @(negedge Clk);
    Reset = 1;
    tick();
    checks++;
    if (Running !== 1'b0 || ProgCtr !== 10'h000) begin
      errors++;
      $display("FAIL idle_hold got pc=%h run=%b exp 000/0", ProgCtr, Running);
    end
  endtask

  task automatic test_sequential();
    start_at(10'h010);
    expect_pc("start_load", 10'h010);
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_pc("seq_incr", 10'h010 + 10'(i));
    end
    checks++;
    if (Running !== 1'b1 || Done !== 1'b0) begin
      errors++;
      $display("FAIL seq_flags got run=%b done=%b exp 1/0", Running, Done);
    end
  endtask

  task automatic test_branch();
    clr(); TargWrEn = 1; TargWrIdx = 2; TargWrData = 8'hFC; tick(); clr();
    start_at(10'h020);
    BranchEn = 1; Zero = 1; TargSel = 2; tick(); clr();
    expect_pc("branch_taken_neg", 10'h01C);
    start_at(10'h020);
    BranchEn = 1; Zero = 0; TargSel = 2; tick(); clr();
    expect_pc("branch_not_taken", 10'h021);
  endtask

  task automatic test_wrap();
    start_at(10'h3FF);
    tick();
    expect_pc("wrap_up", 10'h000);
    clr(); TargWrEn = 1; TargWrIdx = 1; TargWrData = 8'hFE; tick(); clr();
    start_at(10'h001);
    Jump = 1; TargSel = 1; tick(); clr();
    expect_pc("wrap_down", 10'h3FF);
  endtask

  task automatic test_halt();
    start_at(10'h040);
    Ack = 1; Jump = 1; tick(); clr();
    expect_pc("halt_pc", 10'h040);
    for (int i = 0; i < 10; i++) begin
      Jump = 1'($urandom_range(0, 1));
      Stall = 1'($urandom_range(0, 1));
      Ack = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (Done !== 1'b1 || Running !== 1'b0 || ProgCtr !== 10'h040) begin
        errors++;
        $display("FAIL halt_hold got pc=%h run=%b done=%b exp 040/0/1", ProgCtr, Running, Done);
      end
    end
    start_at(10'h000);
    checks++;
    if (Done !== 1'b0 || Running !== 1'b1 || ProgCtr !== 10'h000) begin
      errors++;
      $display("FAIL halt_restart got pc=%h run=%b done=%b exp 000/1/0", ProgCtr, Running, Done);
    end
  endtask

  task automatic test_stall();
    clr(); TargWrEn = 1; TargWrIdx = 0; TargWrData = 8'h05; tick(); clr();
    start_at(10'h050);
    for (int i = 0; i < 3; i++) begin
      Stall = 1; Jump = 1; TargSel = 0; Ack = 1'(i == 1); tick();
      expect_pc("stall_hold", 10'h050);
    end
    clr(); Jump = 1; TargSel = 0; tick(); clr();
    expect_pc("stall_release_jump", 10'h055);
  endtask

  task automatic test_write_collision();
    start_at(10'h060);
    Jump = 1; TargSel = 3; TargWrEn = 1; TargWrIdx = 3; TargWrData = 8'h10; tick(); clr();
    expect_pc("wr_same_cycle_old", 10'h060);
    Jump = 1; TargSel = 3; tick(); clr();
    expect_pc("wr_next_cycle_new", 10'h070);
    #3 Reset = 0;
    #1;
    checks++;
    if ({ProgCtr, Running, Done} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset got pc=%h run=%b done=%b exp 000/0/0", ProgCtr, Running, Done);
    end
    model_reset();
    sb.delete();
    #2 Reset = 1;
    @(negedge Clk);
    start_at(10'h100);
    Jump = 1; TargSel = 3; tick(); clr();
    expect_pc("table_cleared", 10'h100);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      Start      = ($urandom_range(0, 19) == 0);
      StartAddr  = 10'($urandom);
      Stall      = ($urandom_range(0, 5) == 0);
      Ack        = ($urandom_range(0, 24) == 0);
      Jump       = ($urandom_range(0, 4) == 0);
      BranchEn   = 1'($urandom_range(0, 1));
      Zero       = 1'($urandom_range(0, 1));
      TargSel    = 2'($urandom);
      TargWrEn   = ($urandom_range(0, 3) == 0);
      TargWrIdx  = 2'($urandom);
      TargWrData = 8'($urandom);
      tick();
    end
    clr();
  endtask

  initial begin
    clr();
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_halt();
    test_stall();
    test_write_collision();
    test_back_to_back();
    @(posedge Clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
